// File: rtl/tvm_windowed_buffer_pkg.sv
// Shared defaults and helpers for the windowed circular buffer and its RAM.
package tvm_windowed_buffer_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 32;
  localparam int unsigned DEF_CNTR_WIDTH = 6;

  // Pointer width for a DEPTH-entry store; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tvm_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port that holds when idle.
module tvm_buffer_ram
  import tvm_windowed_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read samples the pre-write contents, so a same-slot write/read returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tvm_windowed_buffer.sv
// Circular buffer with windowed random-access read/write ports and independent advances.
module tvm_windowed_buffer
  import tvm_windowed_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH         = DEF_DEPTH,
  parameter int unsigned CNTR_WIDTH    = DEF_CNTR_WIDTH,
  parameter int unsigned RD_WINDOW     = 1,
  parameter int unsigned RD_ADVANCE    = 1,
  parameter int unsigned RD_ADDR_WIDTH = 1,
  parameter int unsigned WR_WINDOW     = 1,
  parameter int unsigned WR_ADVANCE    = 1,
  parameter int unsigned WR_ADDR_WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     read_advance,
  input  logic [RD_ADDR_WIDTH-1:0] read_addr,
  input  logic                     read_ready,
  output logic                     read_valid,
  output logic [DATA_WIDTH-1:0]    read_data,
  input  logic                     write_advance,
  input  logic [WR_ADDR_WIDTH-1:0] write_addr,
  output logic                     write_ready,
  input  logic                     write_valid,
  input  logic [DATA_WIDTH-1:0]    write_data,
  output logic [CNTR_WIDTH-1:0]    status_counter
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  localparam logic [PTR_W:0]        DEPTH_P   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0]      RD_STEP_P = PTR_W'(RD_ADVANCE % DEPTH);
  localparam logic [PTR_W-1:0]      WR_STEP_P = PTR_W'(WR_ADVANCE % DEPTH);
  localparam logic [CNTR_WIDTH-1:0] DEPTH_C   = CNTR_WIDTH'(DEPTH);
  localparam logic [CNTR_WIDTH-1:0] RD_WIN_C  = CNTR_WIDTH'(RD_WINDOW);
  localparam logic [CNTR_WIDTH-1:0] WR_WIN_C  = CNTR_WIDTH'(WR_WINDOW);
  localparam logic [CNTR_WIDTH-1:0] RD_ADV_C  = CNTR_WIDTH'(RD_ADVANCE);
  localparam logic [CNTR_WIDTH-1:0] WR_ADV_C  = CNTR_WIDTH'(WR_ADVANCE);

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNTR_WIDTH-1:0] count_q, count_d;

  logic             rd_fire, wr_fire, rd_adv, wr_adv;
  logic [PTR_W-1:0] rd_addr, wr_addr;

  // Modular add that works for non-power-of-two DEPTH; operands are already < DEPTH.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input logic [PTR_W-1:0] off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= DEPTH_P) begin
      sum = sum - DEPTH_P;
    end
    return sum[PTR_W-1:0];
  endfunction

  assign read_valid     = (count_q >= RD_WIN_C);
  assign write_ready    = ((DEPTH_C - count_q) >= WR_WIN_C);
  assign status_counter = count_q;

  always_comb begin
    rd_fire  = read_ready    && read_valid;
    wr_fire  = write_valid   && write_ready;
    rd_adv   = read_advance  && read_valid;
    wr_adv   = write_advance && write_ready;
    rd_addr  = wrap_add(rd_ptr_q, PTR_W'(read_addr));
    wr_addr  = wrap_add(wr_ptr_q, PTR_W'(write_addr));
    rd_ptr_d = rd_adv ? wrap_add(rd_ptr_q, RD_STEP_P) : rd_ptr_q;
    wr_ptr_d = wr_adv ? wrap_add(wr_ptr_q, WR_STEP_P) : wr_ptr_q;
    count_d  = count_q + (wr_adv ? WR_ADV_C : '0) - (rd_adv ? RD_ADV_C : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  tvm_buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_fire),
    .waddr_i (wr_addr),
    .wdata_i (write_data),
    .re_i    (rd_fire),
    .raddr_i (rd_addr),
    .rdata_o (read_data)
  );

endmodule

// File: tb/tb_tvm_windowed_buffer.sv
// Directed self-checking bench: plain FIFO instance plus a RD_WINDOW=4/RD_ADVANCE=2 instance.
module tb_tvm_windowed_buffer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // FIFO instance (all windows/advances 1)
  logic       a_rd_adv, a_rd_rdy, a_rd_vld, a_wr_adv, a_wr_rdy, a_wr_vld;
  logic [0:0] a_rd_addr, a_wr_addr;
  logic [7:0] a_rd_data, a_wr_data;
  logic [5:0] a_cnt;

  // Windowed-read instance
  logic       b_rd_adv, b_rd_rdy, b_rd_vld, b_wr_adv, b_wr_rdy, b_wr_vld;
  logic [1:0] b_rd_addr;
  logic [0:0] b_wr_addr;
  logic [7:0] b_rd_data, b_wr_data;
  logic [5:0] b_cnt;

  tvm_windowed_buffer dut_a (
    .clk            (clk),
    .rst            (rst),
    .read_advance   (a_rd_adv),
    .read_addr      (a_rd_addr),
    .read_ready     (a_rd_rdy),
    .read_valid     (a_rd_vld),
    .read_data      (a_rd_data),
    .write_advance  (a_wr_adv),
    .write_addr     (a_wr_addr),
    .write_ready    (a_wr_rdy),
    .write_valid    (a_wr_vld),
    .write_data     (a_wr_data),
    .status_counter (a_cnt)
  );

  tvm_windowed_buffer #(
    .DEPTH         (32),
    .RD_WINDOW     (4),
    .RD_ADVANCE    (2),
    .RD_ADDR_WIDTH (2)
  ) dut_b (
    .clk            (clk),
    .rst            (rst),
    .read_advance   (b_rd_adv),
    .read_addr      (b_rd_addr),
    .read_ready     (b_rd_rdy),
    .read_valid     (b_rd_vld),
    .read_data      (b_rd_data),
    .write_advance  (b_wr_adv),
    .write_addr     (b_wr_addr),
    .write_ready    (b_wr_rdy),
    .write_valid    (b_wr_vld),
    .write_data     (b_wr_data),
    .status_counter (b_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_fifo(input logic enq, input logic deq, input logic [7:0] d);
    a_wr_vld  = enq;
    a_wr_adv  = enq;
    a_wr_data = d;
    a_rd_rdy  = deq;
    a_rd_adv  = deq;
  endtask

  task automatic b_write(input logic [7:0] d);
    b_wr_vld  = 1'b1;
    b_wr_adv  = 1'b1;
    b_wr_data = d;
    step();
    b_wr_vld  = 1'b0;
    b_wr_adv  = 1'b0;
  endtask

  logic [7:0] wdat, rexp;

  initial begin
    rst = 1'b1;
    a_rd_addr = '0; a_wr_addr = '0;
    a_fifo(1'b0, 1'b0, 8'h00);
    b_rd_adv = 1'b0; b_rd_rdy = 1'b0; b_rd_addr = '0;
    b_wr_adv = 1'b0; b_wr_vld = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    step();
    step();
    rst = 1'b0;

    check_eq("rst_count", a_cnt, 0);
    check_eq("rst_rvalid", a_rd_vld, 0);
    check_eq("rst_wready", a_wr_rdy, 1);
    check_eq("rst_rdata", a_rd_data, 0);

    // Windowed instance: read window 4, advance 2
    b_write(8'h10); b_write(8'h11); b_write(8'h12);
    check_eq("b_cnt3", b_cnt, 3);
    check_eq("b_rvalid_lo", b_rd_vld, 0);
    b_rd_rdy = 1'b1; b_rd_adv = 1'b1; b_rd_addr = 2'd0;
    step();
    b_rd_rdy = 1'b0; b_rd_adv = 1'b0;
    check_eq("b_noread_data", b_rd_data, 0);
    check_eq("b_noread_cnt", b_cnt, 3);
    b_write(8'h13);
    check_eq("b_cnt4", b_cnt, 4);
    check_eq("b_rvalid_hi", b_rd_vld, 1);
    for (int a = 0; a < 4; a++) begin
      b_rd_rdy = 1'b1; b_rd_addr = 2'(a);
      step();
      check_eq("b_win_read", b_rd_data, 32'h10 + 32'(a));
    end
    b_rd_rdy = 1'b0; b_rd_adv = 1'b1;
    step();
    b_rd_adv = 1'b0;
    check_eq("b_adv_cnt", b_cnt, 2);
    check_eq("b_adv_rvalid", b_rd_vld, 0);
    b_write(8'h14); b_write(8'h15);
    check_eq("b_cnt4b", b_cnt, 4);
    b_rd_rdy = 1'b1; b_rd_addr = 2'd0;
    step();
    check_eq("b_read_off0", b_rd_data, 8'h12);
    b_rd_addr = 2'd3;
    step();
    check_eq("b_read_off3", b_rd_data, 8'h15);
    b_rd_addr = 2'd1; b_rd_adv = 1'b1;
    step();
    b_rd_rdy = 1'b0; b_rd_adv = 1'b0;
    check_eq("b_read_adv_data", b_rd_data, 8'h13);
    check_eq("b_read_adv_cnt", b_cnt, 2);

    // FIFO: fill to full, then one refused write
    for (int i = 0; i < 32; i++) begin
      a_fifo(1'b1, 1'b0, 8'(i));
      step();
    end
    check_eq("full_cnt", a_cnt, 32);
    check_eq("full_wready", a_wr_rdy, 0);
    a_fifo(1'b1, 1'b0, 8'hAA);
    step();
    check_eq("overflow_cnt", a_cnt, 32);

    for (int i = 0; i < 32; i++) begin
      a_fifo(1'b0, 1'b1, 8'h00);
      step();
      check_eq("deq_data", a_rd_data, 32'(i));
    end
    check_eq("empty_cnt", a_cnt, 0);
    check_eq("empty_rvalid", a_rd_vld, 0);

    for (int i = 0; i < 3; i++) step();
    check_eq("underflow_cnt", a_cnt, 0);
    check_eq("underflow_hold", a_rd_data, 8'h1F);

    // Steady state at occupancy 5 with pointer wrap
    wdat = 8'h64;
    rexp = 8'h64;
    for (int i = 0; i < 5; i++) begin
      a_fifo(1'b1, 1'b0, wdat);
      wdat++;
      step();
    end
    check_eq("steady_fill", a_cnt, 5);
    for (int i = 0; i < 100; i++) begin
      a_fifo(1'b1, 1'b1, wdat);
      wdat++;
      step();
      check_eq("steady_data", a_rd_data, rexp);
      check_eq("steady_cnt", a_cnt, 5);
      rexp++;
    end
    a_fifo(1'b0, 1'b0, 8'h00);

    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midrst_cnt", a_cnt, 0);
    check_eq("midrst_rvalid", a_rd_vld, 0);
    check_eq("midrst_wready", a_wr_rdy, 1);
    check_eq("midrst_rdata", a_rd_data, 0);

    // Full with simultaneous read advance and write: only the read is taken
    for (int i = 0; i < 32; i++) begin
      a_fifo(1'b1, 1'b0, 8'h40 + 8'(i));
      step();
    end
    a_fifo(1'b1, 1'b1, 8'hBB);
    step();
    a_fifo(1'b0, 1'b0, 8'h00);
    check_eq("fullrw_cnt", a_cnt, 31);
    check_eq("fullrw_data", a_rd_data, 8'h40);
    check_eq("fullrw_wready", a_wr_rdy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tvm_windowed_buffer.md
# tvm_windowed_buffer

Parameterised circular buffer with windowed, random-access read and write ports and independent advance controls. With all windows and advances set to 1 it behaves as a plain synchronous FIFO. It sits between a producer and a consumer stage of a generated accelerator datapath and reports occupancy through a status counter.

## Interface
- DATA_WIDTH, 8, entry width in bits
- DEPTH, 32, number of entries
- CNTR_WIDTH, 6, occupancy counter width; must satisfy 2^CNTR_WIDTH > DEPTH
- RD_WINDOW, 1, entries that must be present for a read to be valid
- RD_ADVANCE, 1, entries retired per read advance
- RD_ADDR_WIDTH, 1, width of read offset inside the read window
- WR_WINDOW, 1, free entries that must exist for a write to be accepted
- WR_ADVANCE, 1, entries committed per write advance
- WR_ADDR_WIDTH, 1, width of write offset inside the write window

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- read_advance  in  1  retire RD_ADVANCE entries
- read_addr  in  RD_ADDR_WIDTH  offset from read pointer
- read_ready  in  1  consumer requests a read
- read_valid  out  1  read window available
- read_data  out  DATA_WIDTH  registered read result
- write_advance  in  1  commit WR_ADVANCE entries
- write_addr  in  WR_ADDR_WIDTH  offset from write pointer
- write_ready  out  1  write window free
- write_valid  in  1  producer presents write_data
- write_data  in  DATA_WIDTH  data to store
- status_counter  out  CNTR_WIDTH  current occupancy

## Operation
- State: storage of DEPTH entries, rd_ptr, wr_ptr (range 0..DEPTH-1), count (0..DEPTH).
- read_valid = (count >= RD_WINDOW); write_ready = (DEPTH - count >= WR_WINDOW). Both are combinational from count.
- Write: if write_valid && write_ready, store write_data at (wr_ptr + write_addr) mod DEPTH.
- Read: if read_ready && read_valid, read_data <= mem[(rd_ptr + read_addr) mod DEPTH]. Otherwise read_data holds its value.
- Write advance: if write_advance && write_ready, wr_ptr += WR_ADVANCE mod DEPTH.
- Read advance: if read_advance && read_valid, rd_ptr += RD_ADVANCE mod DEPTH.
- Requests that are not qualified are ignored with no state change. This covers a read or advance while not valid, and a write or advance while not ready. It prevents underflow and overflow.
- count_next = count + (write advance accepted ? WR_ADVANCE : 0) - (read advance accepted ? RD_ADVANCE : 0). Simultaneous accepted advances apply both deltas in the same cycle.
- status_counter = count.
- Legal parameters: DEPTH must be a multiple of RD_ADVANCE and of WR_ADVANCE. RD_WINDOW and WR_WINDOW must be <= DEPTH. RD_ADVANCE must be <= RD_WINDOW. Offsets must stay inside their windows. Behaviour outside these limits is undefined.

## Timing
- Reset: count, rd_ptr, wr_ptr and read_data become 0. Memory contents are not reset. After reset, read_valid = 0 and write_ready = 1.
- Reset mid-operation discards all contents on the next edge.
- Read latency is 1 cycle: data requested at edge N is on read_data after edge N.
- A write at edge N is readable from edge N+1. Same-cycle write and read of the same slot returns the old memory value.
- Flags update the cycle after an advance. With all parameters at 1: full when count = DEPTH, empty when count = 0.
- At full with simultaneous read advance and write: the write is refused, because write_ready is 0 in that cycle. Only the read is accepted.
- Pointer wrap: DEPTH-1 + 1 → 0.

## Structure
- No shared package required. Pointer-wrap and occupancy constants are local parameters derived from DEPTH and the window and advance parameters.
- One natural sub-module: tvm_buffer_ram, a simple dual-port RAM with one write port and one registered read port, DEPTH × DATA_WIDTH. The top level holds pointers, counter and flag logic.

## Test plan
Default parameters (DEPTH 32, all windows and advances 1); the FIFO case ties read_ready and read_advance together, and write_valid and write_advance together.
- Reset → status_counter = 0, read_valid = 0, write_ready = 1, read_data = 0.
- Write 0x00..0x1F on 32 consecutive cycles → status_counter = 32, write_ready = 0. A 33rd write is ignored and the count stays 32.
- From full, dequeue 32 times → read_data returns 0x00..0x1F in order, each one cycle after its request. The count ends at 0 and read_valid = 0.
- From empty, hold deq high → nothing is read and the count stays 0, with no underflow.
- Steady state at count 5 with simultaneous enqueue and dequeue for 100 cycles → the count stays 5, data stays in order, and pointers wrap past 31 correctly.
- Parameterised (DEPTH 32, RD_WINDOW 4, RD_ADVANCE 2) → read_valid asserts only when count ≥ 4. read_addr 0..3 returns the 4 oldest entries. Each read advance lowers the count by 2.
